// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: copy/fill block mover that owns the data-memory port while busy
module dmem_copy_engine #(
    parameter int MEM_WORDS = 128,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    input  logic [31:0]      fill_value,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t state;
    logic mode_q, desc_q;
    logic [31:0] src_q, dst_q, fill_q;
    logic [LEN_W-1:0] len_q, idx;
    logic [32:0] dst_end, src_end;
    logic range_err, desc, last;
    logic [LEN_W-1:0] first_idx, next_idx;

    // decode an incoming command (range, direction) and the step to the next word
    always_comb begin
        dst_end = {1'b0, dst_addr} + 33'(length);
        src_end = {1'b0, src_addr} + 33'(length);
        range_err = dst_end > 33'(MEM_WORDS) || (!mode && src_end > 33'(MEM_WORDS));
        desc = !mode && dst_addr > src_addr && {1'b0, dst_addr} < src_end;
        first_idx = desc ? length - 1'b1 : '0;
        last = words_done == len_q - 1'b1;
        next_idx = desc_q ? idx - 1'b1 : idx + 1'b1;
    end

    // command sequencer; mem_write_data doubles as the read buffer in copy mode
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            words_done <= '0;
            mem_address <= '0;
            mem_read <= 1'b0;
            mem_write <= 1'b0;
            mem_write_data <= '0;
            mode_q <= 1'b0;
            desc_q <= 1'b0;
            src_q <= '0;
            dst_q <= '0;
            fill_q <= '0;
            len_q <= '0;
            idx <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_q <= mode;
                    desc_q <= desc;
                    src_q <= src_addr;
                    dst_q <= dst_addr;
                    fill_q <= fill_value;
                    len_q <= length;
                    idx <= first_idx;
                    words_done <= '0;
                    busy <= 1'b1;
                    if (range_err || length == '0) begin
                        state <= DONE;
                        done <= 1'b1;
                        err <= range_err;
                    end else if (mode) begin
                        state <= WR;
                        mem_write <= 1'b1;
                        mem_address <= dst_addr + 32'(first_idx);
                        mem_write_data <= fill_value;
                    end else begin
                        state <= RD;
                        mem_read <= 1'b1;
                        mem_address <= src_addr + 32'(first_idx);
                    end
                end
                RD: begin
                    state <= WR;
                    mem_read <= 1'b0;
                    mem_write <= 1'b1;
                    mem_address <= dst_q + 32'(idx);
                    mem_write_data <= mem_read_data;
                end
                WR: begin
                    words_done <= words_done + 1'b1;
                    idx <= next_idx;
                    if (last) begin
                        state <= DONE;
                        done <= 1'b1;
                        mem_write <= 1'b0;
                        mem_address <= '0;
                        mem_write_data <= '0;
                    end else if (mode_q) begin
                        mem_address <= dst_q + 32'(next_idx);
                        mem_write_data <= fill_q;
                    end else begin
                        state <= RD;
                        mem_write <= 1'b0;
                        mem_read <= 1'b1;
                        mem_address <= src_q + 32'(next_idx);
                        mem_write_data <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b0;
                    err <= 1'b0;
                end
            endcase
        end
    end
endmodule
